inst_fetch_unit: RTL and testbench

Program-counter and instruction-fetch unit directly upstream of the decode stage. It owns the PC, issues word-aligned requests to instruction memory over a valid/ready interface, and buffers in-order responses. It presents `{inst_pc, inst}` to decode with a valid/ready handshake. Execute-stage redirects on taken branches and jumps flush the buffer and discard in-flight responses.

---
 rtl/fetch_defs.sv | 31 +++
 rtl/inst_buffer.sv | 73 +++++++
 rtl/inst_fetch_unit.sv | 92 +++++++++
 tb/tb_inst_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs.sv
// Shared fetch-path types and constants.
// Buffer depth is 2 when RVSV_FETCH_BUF2_EN is defined, otherwise 1.
package fetch_defs;
  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;
  localparam logic [FETCH_ILEN-1:0] NOP_INST = 32'h0000_0013;
`ifdef RVSV_FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  // Storage always has two slots; with DEPTH = 1 only slot 0 is ever addressed.
  localparam int SLOTS = 2;
  localparam int CNT_W = 2;

  typedef logic [0:0]       ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] inst;
    logic                  filled;
  } buf_entry_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t nxt;
    if (p == ptr_t'(DEPTH - 1)) nxt = 1'b0;
    else nxt = p + 1'b1;
    return nxt;
  endfunction
endpackage

// File: rtl/inst_buffer.sv
// Reservation FIFO between instruction memory and decode: entries are reserved
// at request accept, filled in order by responses and dequeued from the head.
module inst_buffer
  import fetch_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  reserve_en,
  input  logic [FETCH_XLEN-1:0] reserve_pc,
  input  logic                  fill_en,
  input  logic [FETCH_ILEN-1:0] fill_inst,
  input  logic                  deq_en,
  output logic                  head_valid,
  output logic [FETCH_XLEN-1:0] head_pc,
  output logic [FETCH_ILEN-1:0] head_inst,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      unfilled
);
  buf_entry_t entries_r [SLOTS];
  ptr_t       head_r;
  ptr_t       tail_r;
  ptr_t       fill_r;
  cnt_t       count_r;
  cnt_t       unfilled_r;

  // Entry storage plus head/tail/fill pointers and occupancy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        entries_r[i] <= '{pc: '0, inst: NOP_INST, filled: 1'b0};
      end
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      fill_r     <= 1'b0;
      count_r    <= 2'd0;
      unfilled_r <= 2'd0;
    end else if (flush) begin
      for (int i = 0; i < SLOTS; i++) begin
        entries_r[i].filled <= 1'b0;
      end
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      fill_r     <= 1'b0;
      count_r    <= 2'd0;
      unfilled_r <= 2'd0;
    end else begin
      if (deq_en) begin
        entries_r[head_r].filled <= 1'b0;
        head_r <= ptr_inc(head_r);
      end
      if (fill_en) begin
        entries_r[fill_r].inst   <= fill_inst;
        entries_r[fill_r].filled <= 1'b1;
        fill_r <= ptr_inc(fill_r);
      end
      // A full buffer may reserve the slot being dequeued this cycle; this write wins.
      if (reserve_en) begin
        entries_r[tail_r].pc     <= reserve_pc;
        entries_r[tail_r].filled <= 1'b0;
        tail_r <= ptr_inc(tail_r);
      end
      count_r    <= count_r + cnt_t'(reserve_en) - cnt_t'(deq_en);
      unfilled_r <= unfilled_r + cnt_t'(reserve_en) - cnt_t'(fill_en);
    end
  end

  assign head_valid = entries_r[head_r].filled;
  assign head_pc    = entries_r[head_r].pc;
  assign head_inst  = entries_r[head_r].inst;
  assign count      = count_r;
  assign unfilled   = unfilled_r;
endmodule

// File: rtl/inst_fetch_unit.sv
// Program counter, fetch-request issue and redirect handling in front of decode.
// Define RVSV_FETCH_BUF2_EN for a two-entry buffer with two requests in flight.
module inst_fetch_unit
  import fetch_defs::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              ILEN     = FETCH_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic [XLEN-1:0] pc_r;
  cnt_t            drop_r;
  cnt_t            drop_nxt_s;
  cnt_t            count_s;
  cnt_t            unfilled_s;
  logic            deq_s;
  logic            accept_s;
  logic            fill_s;
  logic [2:0]      room_s;
  logic [2:0]      used_s;
  logic            redirect_lsb_unused_s;

  assign redirect_lsb_unused_s = ^redirect_pc[1:0];

  assign deq_s  = inst_valid && inst_ready;
  // A same-cycle dequeue frees its slot for the request issued in that cycle.
  assign room_s = 3'(DEPTH) + {2'b00, deq_s};
  assign used_s = {1'b0, count_s} + {1'b0, drop_r};

  // Request issue: blocked in reset and redirect cycles, otherwise needs a free slot.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && !redirect_valid && (room_s > used_s)) imem_req_valid = 1'b1;
    else imem_req_valid = 1'b0;
  end

  assign imem_req_addr = pc_r;
  assign accept_s      = imem_req_valid && imem_req_ready;
  assign fill_s        = imem_rsp_valid && (drop_r == 2'd0) && !redirect_valid;

  // Responses still owed to requests issued before the most recent redirect.
  always_comb begin
    drop_nxt_s = drop_r;
    if (redirect_valid) drop_nxt_s = drop_r + unfilled_s - cnt_t'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_r != 2'd0)) drop_nxt_s = drop_r - 2'd1;
    else drop_nxt_s = drop_r;
  end

  // PC and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= RESET_PC;
      drop_r <= 2'd0;
    end else begin
      drop_r <= drop_nxt_s;
      if (redirect_valid) pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept_s) pc_r <= pc_r + PC_STEP;
      else pc_r <= pc_r;
    end
  end

  inst_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .reserve_en(accept_s),
    .reserve_pc(pc_r),
    .fill_en   (fill_s),
    .fill_inst (imem_rsp_data),
    .deq_en    (deq_s),
    .head_valid(inst_valid),
    .head_pc   (inst_pc),
    .head_inst (inst),
    .count     (count_s),
    .unfilled  (unfilled_s)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: an in-order memory model plus a
// per-path sequence model of what decode must receive.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef RVSV_FETCH_BUF2_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: a bijective scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;
  int          cyc = 0;

  logic [31:0] exp_pc, exp_req;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_inst, prev_pc;
  int          deq_total = 0;

  int          lat_min = 1, lat_max = 1, p_rdy = 100, p_req_rdy = 100, p_redir = 0;
  logic        force_redir = 1'b0;
  logic        redir_on_deq_rsp = 1'b0;
  logic [31:0] force_target = 32'h0;

  logic [31:0] s_req_valid, s_req_addr, s_acc, s_deq, s_redir, s_inst_valid, s_inst_pc;

  task automatic apply_reset(input int n);
    mq_addr.delete();
    mq_due.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      #1;
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      if (i > 0) begin
        check_eq("rst_req_addr", imem_req_addr, RST_PC);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
      end
      @(posedge clk);
      cyc++;
    end
    last_due  = cyc;
    exp_pc    = RST_PC;
    exp_req   = RST_PC;
    hold_prev = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample and check 1 ns later, commit at posedge.
  task automatic step();
    logic [31:0] tgt;
    logic        rsp_now;
    int          due;
    @(negedge clk);
    rst = 1'b0;
    rsp_now = (mq_due.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mq_addr[0]) : 32'h0;
    if (rsp_now) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    inst_ready     = ($urandom_range(99) < p_rdy);
    imem_req_ready = ($urandom_range(99) < p_req_rdy);
    redirect_valid = 1'b0;
    tgt = $urandom;
    if (force_redir) begin
      redirect_valid = 1'b1; tgt = force_target; force_redir = 1'b0;
    end else if (redir_on_deq_rsp && inst_valid && (TB_DEPTH == 1 || rsp_now)) begin
      redirect_valid = 1'b1; inst_ready = 1'b1; redir_on_deq_rsp = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
    end
    redirect_pc = tgt;
    #1;
    s_req_valid  = 32'(imem_req_valid);
    s_req_addr   = imem_req_addr;
    s_acc        = 32'(imem_req_valid && imem_req_ready);
    s_deq        = 32'(inst_valid && inst_ready);
    s_redir      = 32'(redirect_valid);
    s_inst_valid = 32'(inst_valid);
    s_inst_pc    = inst_pc;
    if (hold_prev) begin
      check_eq("hold_valid", 32'(inst_valid), 32'd1);
      check_eq("hold_inst", inst, prev_inst);
      check_eq("hold_pc", inst_pc, prev_pc);
    end
    if (inst_valid && inst_ready) begin
      check_eq("deq_pc", inst_pc, exp_pc);
      check_eq("deq_inst", inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      deq_total++;
    end
    if (redirect_valid) check_eq("req_in_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req);
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
      exp_req = exp_req + 32'd4;
      check_eq("outstanding_le_depth", 32'(mq_addr.size() <= TB_DEPTH), 32'd1);
    end
    if (redirect_valid) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end
    hold_prev = inst_valid && !inst_ready && !redirect_valid;
    prev_inst = inst;
    prev_pc   = inst_pc;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int   base;
    int   nacc;
    logic got_req, got_deq, seen;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

    // Reset release, L = 1, everything ready.
    apply_reset(2);
    base = deq_total;
    step();
    check_eq("r0_req_valid", s_req_valid, 32'd1);
    check_eq("r0_req_addr", s_req_addr, RST_PC);
    step();
    check_eq("r1_req_valid", s_req_valid, 32'(TB_DEPTH == 2));
    check_eq("r1_req_addr", s_req_addr, RST_PC + 32'd4);
    step();
    check_eq("r2_req_valid", s_req_valid, 32'd1);
    check_eq("r2_req_addr", s_req_addr, RST_PC + ((TB_DEPTH == 2) ? 32'd8 : 32'd4));
    check_eq("r2_inst_valid", s_inst_valid, 32'd1);
    check_eq("r2_inst_pc", s_inst_pc, RST_PC);
    repeat (19) step();
    check_eq("throughput", 32'(deq_total - base), (TB_DEPTH == 2) ? 32'd20 : 32'd10);

    // Decode stall with a full buffer.
    p_rdy = 0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_req_valid", s_req_valid, 32'd0);
    end
    p_rdy = 100;
    base = deq_total;
    repeat (10) step();
    check_eq("stall_release_progress", 32'(deq_total - base >= 4), 32'd1);

    // Redirect with requests in flight.
    apply_reset(2);
    lat_min = 3; lat_max = 3;
    step();
    step();
    force_redir = 1'b1; force_target = 32'h0000_0203;
    step();
    check_eq("redir_req_valid", s_req_valid, 32'd0);
    check_eq("redir_inflight", 32'(mq_addr.size()), 32'(TB_DEPTH));
    got_req = 1'b0; got_deq = 1'b0;
    for (int i = 0; i < 40 && !got_deq; i++) begin
      step();
      if (s_req_valid[0] && !got_req) begin
        got_req = 1'b1;
        check_eq("redir_first_req", s_req_addr, 32'h0000_0200);
      end
      if (s_deq[0]) begin
        got_deq = 1'b1;
        check_eq("redir_first_pc", s_inst_pc, 32'h0000_0200);
      end
    end
    check_eq("redir_deq_seen", 32'(got_deq), 32'd1);

    // Redirect coinciding with a dequeue (and a response when two entries exist).
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    redir_on_deq_rsp = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = s_redir[0];
    end
    check_eq("coinc_redir_seen", 32'(seen), 32'd1);
    check_eq("coinc_deq", s_deq, 32'd1);
    check_eq("coinc_req_valid", s_req_valid, 32'd0);
    step();
    check_eq("coinc_empty_after", s_inst_valid, 32'd0);

    // PC wrap.
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    step();
    nacc = 0;
    for (int i = 0; i < 40 && nacc < 2; i++) begin
      step();
      if (s_acc[0]) begin
        check_eq("wrap_addr", s_req_addr, (nacc == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
        nacc++;
      end
    end
    check_eq("wrap_seen", 32'(nacc), 32'd2);

    // Unaccepted request withdrawn by redirect.
    apply_reset(2);
    p_req_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("nrdy_req_valid", s_req_valid, 32'd1);
      check_eq("nrdy_req_addr", s_req_addr, RST_PC);
    end
    p_req_rdy = 100;
    force_redir = 1'b1; force_target = 32'h0000_0300;
    step();
    check_eq("withdraw_req_valid", s_req_valid, 32'd0);
    step();
    check_eq("withdraw_next_valid", s_req_valid, 32'd1);
    check_eq("withdraw_next_addr", s_req_addr, 32'h0000_0300);

    // Random traffic.
    apply_reset(2);
    lat_min = 1; lat_max = 4; p_rdy = 70; p_req_rdy = 70; p_redir = 3;
    repeat (3000) step();

    // Reset in the middle of traffic, then a bounded progress check.
    apply_reset(2);
    lat_min = 1; lat_max = 1; p_rdy = 100; p_req_rdy = 100; p_redir = 0;
    base = deq_total;
    repeat (30) step();
    check_eq("drain_progress", 32'(deq_total - base >= 8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
